serial_to_parallel_receiver: RTL and testbench
==============================================

# serial_to_parallel_receiver

Serial-in, parallel-out receiver for the multiplier datapath. It collects a WORD_LENGTH-bit word shifted in LSB-first, one bit per `shift` strobe, and presents the completed word on a ready/valid output port. It is the receive end of the parallel-load/right-shift serializer used elsewhere in the multiplier. A one-word output buffer, a bit counter and a small FSM absorb back-pressure and flag overrun.

## Interface
- WORD_LENGTH, 4, word width in bits (≥2)
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  begin (or restart) collection of a new word
- shift  input  1  bit strobe; `serialInput` is sampled when high
- serialInput  input  1  serial data, LSB first
- outReady  input  1  consumer accepts `parallelOutput` this cycle
- parallelOutput  output  WORD_LENGTH  buffered completed word
- outValid  output  1  `parallelOutput` holds an unconsumed word
- busy  output  1  FSM not in IDLE
- overrun  output  1  sticky; a shift strobe arrived in WAIT

## Operation
- Collection register `shreg` shifts right: `shreg <= {serialInput, shreg[WL-1:1]}`. After WL shifts, the first bit received is in bit 0.
- Bit counter `cnt`, width $clog2(WORD_LENGTH), counts 0..WL-1.
- **IDLE:**
  - `start` → COLLECT; `cnt`←0; `shreg`←0; `overrun`←0.
  - `shift` alone is ignored.
- **COLLECT:**
  - `start` (with or without `shift`) restarts: `cnt`←0, `shreg`←0, stay in COLLECT. The bit on that cycle is discarded.
  - `shift` with `cnt`<WL-1: shift in, `cnt`++.
  - `shift` with `cnt`==WL-1: word complete (`wordNext` = {serialInput, shreg[WL-1:1]}).
    - Buffer free (`!outValid || outReady`): `parallelOutput`←`wordNext`, `outValid`←1, → IDLE.
    - Otherwise: `shreg`←`wordNext`, → WAIT.
- **WAIT:**
  - `shift` sets `overrun`; the bit is dropped.
  - `start` is ignored.
  - When the buffer is free: `parallelOutput`←`shreg`, `outValid`←1, → IDLE.
- **Output handshake:**
  - A word is consumed on an edge with `outValid && outReady`.
  - `outValid` then falls unless a new word loads on the same edge; the load takes priority and keeps `outValid`=1.
  - `parallelOutput` is stable while `outValid`=1 and not consumed.
- `busy` = (state != IDLE).
- `overrun` clears only on reset or a `start` accepted in IDLE.

## Timing
- **Reset:** state IDLE, `cnt`=0, `shreg`=0, `parallelOutput`=0, `outValid`=0, `busy`=0, `overrun`=0. Takes effect immediately and asynchronously; a partial word is lost.
- **Start:** `busy` rises on the edge that samples `start`.
- **Latency, buffer free:** `outValid` rises on the same edge that samples the WL-th bit, i.e. one edge after the final `shift` is presented.
- **Latency, buffer full:** the word transfers on the edge where `outReady`=1. `outValid` stays high through the swap, so back-to-back words need no bubble.
- **Throughput:**
  - Minimum frame is WL+1 cycles: 1 `start` cycle plus WL `shift` cycles.
  - `start` may be asserted on the cycle after completion (state IDLE).
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Package `serial_rx_pkg`:
  - state enum {IDLE, COLLECT, WAIT}, 2-bit encoding.
  - function `cnt_width(WL)` returning $clog2(WL).
- Sub-module `rx_bit_counter`: counter with clear, enable and terminal-count output (`cnt`==WL-1).
- Top module holds the FSM, `shreg`, output buffer and `overrun`.

## Test plan
(all with WORD_LENGTH=4)
- **Basic frame:** `start`, then bits 1,0,1,1 with `shift`=1 and `outReady`=0 → `parallelOutput`=4'hD and `outValid`=1 on the 4th shift edge; `busy` falls on that edge.
- **Back-pressure:** first word 4'hD held with `outReady`=0; second frame 0,1,1,0 → state WAIT, `busy`=1. Then `outReady`=1 for one cycle → 4'hD consumed and 4'h6 loaded on the same edge, `outValid` stays 1.
- **Overrun:** in WAIT, one `shift` strobe → `overrun`=1 and held. A later `start` in IDLE → `overrun`=0.
- **Restart:** after 2 bits, `start`+`shift` in the same cycle, then bits 0,0,0,1 → 4'h8; the pre-restart bits have no effect.
- **Async reset mid-frame:** `reset`=0 after 3 bits, between edges → all outputs 0 immediately. After release, a new 4-bit frame yields the correct word.
- **Idle noise:** `shift` toggling in IDLE with random `serialInput` → no state change, `outValid` stays 0.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT    = 2'd2
  } rx_state_e;

  function automatic int cnt_width(input int wl);
    return $clog2(wl);
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Bit counter for the receiver: clear, enable and a terminal-count flag at WL-1.
module rx_bit_counter
  import serial_rx_pkg::*;
#(
  parameter int WL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(WL);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CW'(WL - 1));

endmodule

// File: rtl/serial_to_parallel_receiver.sv
// LSB-first serial collector with a one-word ready/valid output buffer and sticky overrun flag.
//
// state   | meaning
// IDLE    | no frame in progress; waiting for start
// COLLECT | shifting bits into shreg
// WAIT    | word complete in shreg, output buffer still occupied
module serial_to_parallel_receiver
  import serial_rx_pkg::*;
#(
  parameter int WORD_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   shift,
  input  logic                   serialInput,
  input  logic                   outReady,
  output logic [WORD_LENGTH-1:0] parallelOutput,
  output logic                   outValid,
  output logic                   busy,
  output logic                   overrun
);

  rx_state_e              state_q, state_d;
  logic [WORD_LENGTH-1:0] shreg_q, shreg_d;
  logic [WORD_LENGTH-1:0] out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   cnt_clr, cnt_en, cnt_tc;
  logic                   buf_free;
  logic [WORD_LENGTH-1:0] word_next;

  rx_bit_counter #(.WL(WORD_LENGTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign buf_free  = !out_valid_q || outReady;
  assign word_next = {serialInput, shreg_q[WORD_LENGTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    // Consumption first; a same-edge load below overrides it.
    if (out_valid_q && outReady)
      out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          shreg_d   = '0;
          overrun_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      COLLECT: begin
        if (start) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
        end else if (shift) begin
          if (!cnt_tc) begin
            shreg_d = word_next;
            cnt_en  = 1'b1;
          end else if (buf_free) begin
            out_d       = word_next;
            out_valid_d = 1'b1;
            state_d     = IDLE;
            cnt_clr     = 1'b1;
          end else begin
            shreg_d = word_next;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (shift)
          overrun_d = 1'b1;
        if (buf_free) begin
          out_d       = shreg_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
          cnt_clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign parallelOutput = out_q;
  assign outValid       = out_valid_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Directed bench: expected words go into a scoreboard queue, a negedge monitor checks each consumed word.
module tb_serial_to_parallel_receiver;

  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          shift = 1'b0;
  logic          serialInput = 1'b0;
  logic          outReady = 1'b0;
  logic [WL-1:0] parallelOutput;
  logic          outValid;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  logic [WL-1:0] sb[$];

  serial_to_parallel_receiver #(.WORD_LENGTH(WL)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .shift          (shift),
    .serialInput    (serialInput),
    .outReady       (outReady),
    .parallelOutput (parallelOutput),
    .outValid       (outValid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift the low n bits of w, LSB first, one per cycle.
  task automatic send_bits(input logic [WL-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      shift = 1'b1;
      serialInput = w[i];
      tick();
    end
    shift = 1'b0;
    serialInput = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && outValid && outReady) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h required=none", parallelOutput);
      end else begin
        logic [WL-1:0] e;
        e = sb.pop_front();
        check("consumed_word", parallelOutput, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_pout", parallelOutput, 0);
    check("rst_valid", outValid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1;
    tick();

    // Basic frame: 1,0,1,1 -> D
    sb.push_back(4'hD);
    do_start();
    check("start_busy", busy, 1);
    send_bits(4'hD, 3);
    check("basic_valid_early", outValid, 0);
    shift = 1'b1; serialInput = 1'b1; tick(); shift = 1'b0;
    check("basic_valid", outValid, 1);
    check("basic_word", parallelOutput, 4'hD);
    check("basic_busy", busy, 0);

    // Back-pressure: 0,1,1,0 -> 6 held in WAIT
    sb.push_back(4'h6);
    do_start();
    send_bits(4'h6, 4);
    check("bp_busy", busy, 1);
    check("bp_valid", outValid, 1);
    check("bp_hold_word", parallelOutput, 4'hD);

    // Overrun in WAIT
    shift = 1'b1; serialInput = 1'b1; tick(); shift = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_busy", busy, 1);
    tick();
    check("ovr_sticky", overrun, 1);
    check("ovr_hold_word", parallelOutput, 4'hD);

    // One-cycle ready: D consumed, 6 loaded on same edge
    outReady = 1'b1; tick(); outReady = 1'b0;
    check("swap_valid", outValid, 1);
    check("swap_word", parallelOutput, 4'h6);
    check("swap_busy", busy, 0);
    check("swap_overrun", overrun, 1);
    outReady = 1'b1; tick(); outReady = 1'b0;
    check("drain_valid", outValid, 0);

    // Start in IDLE clears overrun; restart after 2 bits -> 8
    do_start();
    check("ovr_clear", overrun, 0);
    send_bits(4'h3, 2);
    start = 1'b1; shift = 1'b1; serialInput = 1'b1; tick();
    start = 1'b0; shift = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_valid", outValid, 0);
    sb.push_back(4'h8);
    outReady = 1'b1;
    send_bits(4'h8, 4);
    check("restart_valid2", outValid, 1);
    check("restart_word", parallelOutput, 4'h8);
    tick();
    outReady = 1'b0;
    check("restart_consumed", outValid, 0);

    // Async reset mid-frame
    do_start();
    send_bits(4'hF, 3);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_pout", parallelOutput, 0);
    check("arst_valid", outValid, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    tick();
    reset = 1'b1;
    tick();
    do_start();
    sb.push_back(4'hA);
    outReady = 1'b1;
    send_bits(4'hA, 4);
    check("post_rst_valid", outValid, 1);
    check("post_rst_word", parallelOutput, 4'hA);
    tick();
    outReady = 1'b0;

    // Idle noise
    for (int i = 0; i < 8; i++) begin
      shift = i[0];
      serialInput = 1'($urandom_range(0, 1));
      tick();
      check("idle_busy", busy, 0);
      check("idle_valid", outValid, 0);
      check("idle_word", parallelOutput, 4'hA);
    end
    shift = 1'b0;
    tick();

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
